// File: rtl/ble_whiten_pkg.sv
// Shared constants, FSM encoding and bit-count helper for the BLE whitening
// controller and its bit counters.
package ble_whiten_pkg;

    localparam int unsigned CRC_BITS_DEF = 24;
    localparam int unsigned MAX_CHAN_DEF = 39;
    localparam int unsigned CNT_W        = 12;
    localparam int unsigned CHAN_W       = 6;
    localparam int unsigned LEN_W        = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [CHAN_W-1:0] chan_t;
    typedef logic [LEN_W-1:0]  len_t;

    // Bits on air for one packet: PDU bytes times eight plus the CRC tail.
    function automatic cnt_t bit_total(input len_t len, input int unsigned crc);
        return CNT_W'({len, 3'b000}) + CNT_W'(crc);
    endfunction

endpackage

// File: rtl/ble_whiten_ctrl_if.sv
// Serial stream and whitener hookup between the controller (master) and its
// surroundings: upstream source, external whitener and downstream sink.
interface ble_whiten_ctrl_if;
    import ble_whiten_pkg::*;

    logic        s_valid;
    logic        s_data;
    logic        s_ready;
    logic        w_enable;
    chan_t       w_int_d;
    logic        w_valid_in;
    logic        w_data_in;
    logic        w_valid_out;
    logic        w_data_out;
    logic        m_valid;
    logic        m_data;

    modport master (
        input  s_valid, s_data, w_valid_out, w_data_out,
        output s_ready, w_enable, w_int_d, w_valid_in, w_data_in, m_valid, m_data
    );

    modport slave (
        output s_valid, s_data, w_valid_out, w_data_out,
        input  s_ready, w_enable, w_int_d, w_valid_in, w_data_in, m_valid, m_data
    );

endinterface

// File: rtl/ble_bit_counter.sv
// Loadable down-counter with saturation at zero; reports zero and
// "one bit left" so the controller can act on the final decrement.
module ble_bit_counter import ble_whiten_pkg::*; #(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous and checked first.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/ble_whiten_ctrl.sv
// Packet sequencer in front of an external BLE whitener: seeds it from the
// channel index, feeds the PDU+CRC bit stream through, and counts bits out.
module ble_whiten_ctrl import ble_whiten_pkg::*; #(
    parameter int unsigned CRC_BITS = CRC_BITS_DEF,
    parameter int unsigned MAX_CHAN = MAX_CHAN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAN_W-1:0] chan_idx,
    input  logic [LEN_W-1:0]  pdu_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    ble_whiten_ctrl_if.master bus
);

    localparam chan_t MAX_CHAN_L = CHAN_W'(MAX_CHAN);

    logic [1:0] state_q, state_d;
    chan_t      chan_q, chan_d;
    logic       w_valid_in_q, w_valid_in_d;
    logic       w_data_in_q, w_data_in_d;
    logic       err_q, err_d;
    logic       done_q, done_d;

    logic       cnt_load;
    cnt_t       cnt_init;
    logic       in_dec, in_zero, in_last;
    logic       out_dec, out_zero, out_last;
    logic       in_run, in_drain, active;

    assign in_run   = (state_q == ST_RUN);
    assign in_drain = (state_q == ST_DRAIN);
    assign active   = in_run || in_drain;
    assign cnt_init = bit_total(pdu_len, CRC_BITS);

    assign in_dec  = in_run && bus.s_valid && !in_zero;
    assign out_dec = active && bus.w_valid_out && !out_zero;

    ble_bit_counter #(.W(CNT_W)) u_in_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_init),
        .dec_i      (in_dec),
        .zero_o     (in_zero),
        .last_o     (in_last)
    );

    ble_bit_counter #(.W(CNT_W)) u_out_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_init),
        .dec_i      (out_dec),
        .zero_o     (out_zero),
        .last_o     (out_last)
    );

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        err_d        = 1'b0;
        done_d       = 1'b0;
        w_valid_in_d = 1'b0;
        w_data_in_d  = 1'b0;
        cnt_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (chan_idx <= MAX_CHAN_L) begin
                        chan_d   = chan_idx;
                        cnt_load = 1'b1;
                        state_d  = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A gap would make the whitener reseed mid-packet, so it is fatal.
                if (!bus.s_valid) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    w_valid_in_d = 1'b1;
                    w_data_in_d  = bus.s_data;
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_dec && out_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything else once a packet is under way.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            err_d        = 1'b0;
            done_d       = 1'b0;
            w_valid_in_d = 1'b0;
            w_data_in_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            chan_q       <= '0;
            w_valid_in_q <= 1'b0;
            w_data_in_q  <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            w_valid_in_q <= w_valid_in_d;
            w_data_in_q  <= w_data_in_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign bus.s_ready    = in_run;
    assign bus.w_enable   = active;
    assign bus.w_int_d    = chan_q;
    assign bus.w_valid_in = w_valid_in_q;
    assign bus.w_data_in  = w_data_in_q;
    assign bus.m_valid    = active && bus.w_valid_out;
    assign bus.m_data     = active && bus.w_data_out;

endmodule
